// File: rtl/poly1305_msgfeed_pkg.sv
// Shared constants and types for the poly1305 message feeder and core wrapper.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package poly1305_pkg;

  localparam int BLK_W     = 128;
  localparam int BLK_BYTES = BLK_W / 8;

  // Appended after the last message byte of a partial block.
  localparam logic [7:0] PAD_BYTE = 8'h01;

  // Clamp applied to the r half of the one-time key.
  localparam logic [BLK_W-1:0] RCLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TAG   = 2'd3
  } state_t;

endpackage

// File: rtl/poly1305_msgfeed_if.sv
// Bundle between a word-stream source / poly1305 core and the message feeder.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the word stream; blk_ld/blk_rdy toward the core.
// Ports: in_* = message words, blk_* = block handoff to the core, tag_valid/busy = status.
interface poly1305_msgfeed_if #(
  parameter int IN_W = 32,
  parameter int BW   = $clog2(IN_W / 8) + 1
);

  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [BW-1:0]   in_bytes;
  logic [127:0]    blk_m;
  logic            blk_fb;
  logic            blk_ld;
  logic            blk_first;
  logic            blk_rdy;
  logic            tag_valid;
  logic            busy;

  // Source of words and responder for the core handshake.
  modport master (
    output in_data, in_valid, in_last, in_bytes, blk_rdy,
    input  in_ready, blk_m, blk_fb, blk_ld, blk_first, tag_valid, busy
  );

  // The feeder itself.
  modport slave (
    input  in_data, in_valid, in_last, in_bytes, blk_rdy,
    output in_ready, blk_m, blk_fb, blk_ld, blk_first, tag_valid, busy
  );

endinterface

// File: rtl/poly1305_padmask.sv
// Zeroes block bytes at index >= i_n and, for a partial block, writes the 0x01 pad at byte i_n.
// Latency: combinational.
// Backpressure: none.
// Ports: i_blk raw buffer, i_n valid byte count (0..16), i_partial pad enable, o_blk padded block.
module poly1305_padmask
  import poly1305_pkg::*;
(
  input  logic [BLK_W-1:0] i_blk,
  input  logic [4:0]       i_n,
  input  logic             i_partial,
  output logic [BLK_W-1:0] o_blk
);

  always_comb begin
    o_blk = '0;
    for (int b = 0; b < BLK_BYTES; b++) begin
      if (5'(b) < i_n) begin
        o_blk[8*b +: 8] = i_blk[8*b +: 8];
      end else if (i_partial && (5'(b) == i_n)) begin
        o_blk[8*b +: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/poly1305_msgfeed.sv
// Packs little-endian message words into 128-bit poly1305 blocks, pads the tail, drives the core.
// Latency: block load pulse one cycle after the word completing it; tag flag one cycle after blk_rdy.
// Backpressure: in_ready is low from block issue until the core returns blk_rdy (no fill/compute overlap).
// Ports: clk, reset (sync, active-low), bus = word stream in + core block handoff out + status.
module poly1305_msgfeed
  import poly1305_pkg::*;
#(
  parameter int IN_W = 32,
  parameter int BW   = $clog2(IN_W / 8) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  poly1305_msgfeed_if.slave     bus
);

  localparam int BPW    = IN_W / 8;
  localparam int WPB    = BLK_W / IN_W;
  localparam int WIDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WPB - 1);

  state_t             r_state;
  logic [WIDX_W-1:0]  r_widx;
  logic [BLK_W-1:0]   r_buf;
  logic               r_first_pend;
  logic               r_last_pend;
  logic               r_fb;
  logic               r_first;
  logic               r_ld;
  logic               r_tag;
  logic               r_busy;

  logic               w_in_ready;
  logic               w_accept;
  logic [BW-1:0]      w_bytes_eff;
  logic [4:0]         w_n;
  logic               w_partial;
  logic [BLK_W-1:0]   w_buf_wr;
  logic [BLK_W-1:0]   w_blk_pad;

  // Gating with reset keeps in_ready low during the reset cycle itself.
  assign w_in_ready = (r_state == ST_FILL) && reset;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Out-of-range byte counts on a last word mean a full word.
  always_comb begin
    w_bytes_eff = bus.in_bytes;
    if ((bus.in_bytes == '0) || (bus.in_bytes > BW'(BPW))) begin
      w_bytes_eff = BW'(BPW);
    end
  end

  assign w_n       = 5'(BPW * int'(r_widx) + int'(w_bytes_eff));
  assign w_partial = (w_n != 5'(BLK_BYTES));

  always_comb begin
    w_buf_wr = r_buf;
    w_buf_wr[IN_W*r_widx +: IN_W] = bus.in_data;
  end

  // Bytes above the current word are already zero (buffer cleared per block), so
  // masking from byte n upward only strips the unused lanes of the last word.
  poly1305_padmask u_padmask (
    .i_blk     (w_buf_wr),
    .i_n       (w_n),
    .i_partial (w_partial),
    .o_blk     (w_blk_pad)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_FILL;
      r_widx       <= '0;
      r_buf        <= '0;
      r_first_pend <= 1'b1;
      r_last_pend  <= 1'b0;
      r_fb         <= 1'b0;
      r_first      <= 1'b0;
      r_ld         <= 1'b0;
      r_tag        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ld  <= 1'b0;
      r_tag <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (bus.in_last) begin
              r_buf       <= w_blk_pad;
              r_fb        <= !w_partial;
              r_last_pend <= 1'b1;
              r_widx      <= '0;
              r_ld        <= 1'b1;
              r_first     <= r_first_pend;
              r_state     <= ST_ISSUE;
            end else if (r_widx == WIDX_LAST) begin
              r_buf   <= w_buf_wr;
              r_fb    <= 1'b1;
              r_widx  <= '0;
              r_ld    <= 1'b1;
              r_first <= r_first_pend;
              r_state <= ST_ISSUE;
            end else begin
              r_buf  <= w_buf_wr;
              r_widx <= r_widx + 1'b1;
            end
          end
        end
        // r_ld was raised on entry, so the load pulse spans exactly this cycle.
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (bus.blk_rdy) begin
            r_buf        <= '0;
            r_first_pend <= 1'b0;
            if (r_last_pend) begin
              r_tag   <= 1'b1;
              r_state <= ST_TAG;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_TAG: begin
          r_first_pend <= 1'b1;
          r_last_pend  <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= ST_FILL;
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.blk_m     = r_buf;
  assign bus.blk_fb    = r_fb;
  assign bus.blk_ld    = r_ld;
  assign bus.blk_first = r_first;
  assign bus.tag_valid = r_tag;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_poly1305_msgfeed.sv
module tb_poly1305_msgfeed;
  import poly1305_pkg::*;

  localparam logic [259:0] PRIME = (260'(1) << 130) - 260'd5;
  localparam logic [127:0] R_RAW = 128'ha806d542fe52447f336d555778bed685;
  localparam logic [127:0] S_KEY = 128'h1bf54941aff6bf4afdb20dfb8a800301;
  localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;

  typedef struct {
    int           len;
    logic [7:0]   seed;
    bit           stall;
    bit           bz;
    bit           rfc;
    int           nblk;
    logic [2:0]   fb;
    logic [127:0] last_m;
  } vec_t;

  logic clk;
  logic reset;

  poly1305_msgfeed_if #(.IN_W(32)) if32 ();
  poly1305_msgfeed_if #(.IN_W(8))  if8 ();

  poly1305_msgfeed #(.IN_W(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  poly1305_msgfeed #(.IN_W(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic logic [129:0] poly_step(logic [129:0] h, logic [127:0] m,
                                             logic fb, logic [127:0] r);
    logic [259:0] t;
    t = 260'(h) + 260'(m) + (fb ? (260'(1) << 128) : 260'(0));
    t = t * 260'(r);
    for (int k = 0; k < 3; k++) t = 260'(t[129:0]) + 260'(t[259:130]) * 260'd5;
    if (t >= PRIME) t = t - PRIME;
    return t[129:0];
  endfunction

  // ---------------- reference core for the 32-bit feeder ----------------
  logic [127:0] r_key;
  logic [129:0] acc;
  logic [127:0] cap_m;
  logic         cap_fb, cap_first;
  logic [127:0] last_tag;
  logic         core_rdy_next, prev_rdy;
  int           core_cnt = 0;
  int           core_lat = 3;
  bit           force_rdy = 0;
  int           tag_cnt = 0, ld_cnt = 0, ready_viol = 0, tag_misalign = 0;
  logic [127:0] q_m[$];
  logic         q_fb[$];
  logic         q_first[$];

  initial begin
    r_key = R_RAW & RCLAMP;
    acc = '0;
    last_tag = '0;
    if32.blk_rdy = 1'b0;
    forever begin
      @(negedge clk);
      prev_rdy = if32.blk_rdy;
      core_rdy_next = 1'b0;
      if (if32.tag_valid) begin
        tag_cnt++;
        last_tag = 128'(acc + 130'(S_KEY));
        if (!prev_rdy) tag_misalign++;
      end
      if (if32.blk_ld) begin
        ld_cnt++;
        cap_m = if32.blk_m; cap_fb = if32.blk_fb; cap_first = if32.blk_first;
        q_m.push_back(cap_m); q_fb.push_back(cap_fb); q_first.push_back(cap_first);
        core_cnt = core_lat;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_rdy_next = 1'b1;
          chk("hold_m", if32.blk_m, cap_m);
          chk("hold_fb", 128'(if32.blk_fb), 128'(cap_fb));
          chk("hold_first", 128'(if32.blk_first), 128'(cap_first));
          acc = poly_step(cap_first ? 130'd0 : acc, cap_m, cap_fb, r_key);
        end
      end
      if ((if32.blk_ld || core_cnt > 0 || core_rdy_next) && if32.in_ready) ready_viol++;
      if32.blk_rdy = core_rdy_next | force_rdy;
    end
  end

  // ---------------- simple responder for the 8-bit feeder ----------------
  int           c8 = 0, tag8 = 0;
  logic         r8;
  logic [127:0] q8_m[$];
  logic         q8_fb[$];

  initial begin
    if8.blk_rdy = 1'b0;
    forever begin
      @(negedge clk);
      r8 = 1'b0;
      if (if8.tag_valid) tag8++;
      if (if8.blk_ld) begin
        q8_m.push_back(if8.blk_m); q8_fb.push_back(if8.blk_fb); c8 = 2;
      end else if (c8 > 0) begin
        c8--;
        if (c8 == 0) r8 = 1'b1;
      end
      if8.blk_rdy = r8;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] msg [0:63];
  vec_t       tbl [8];

  task automatic send32(input int len, input bit stall, input bit bz, input bit nolast);
    int nw, rem, guard;
    logic [31:0] d;
    nw = (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if (stall && (w % 2 == 1)) begin
        if32.in_valid = 1'b0;
        @(negedge clk);
      end
      for (int k = 0; k < 4; k++)
        d[8*k +: 8] = (4*w + k < len) ? msg[4*w + k] : 8'hEE;
      rem = len - 4*w;
      if32.in_data  = d;
      if32.in_last  = (w == nw - 1) && !nolast;
      if32.in_bytes = if32.in_last ? ((rem >= 4) ? (bz ? 3'd0 : 3'd4) : 3'(rem)) : 3'd1;
      if32.in_valid = 1'b1;
      guard = 0;
      while (!if32.in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) chk("in_ready_timeout", 128'(guard), 128'd0);
      @(negedge clk);
    end
    if32.in_valid = 1'b0;
    if32.in_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int guard, t0;
    string str;
    q_m.delete(); q_fb.delete(); q_first.delete();
    ready_viol = 0; tag_misalign = 0;
    t0 = tag_cnt;
    str = "Cryptographic Forum Research Group";
    for (int i = 0; i < v.len; i++) msg[i] = v.rfc ? str[i] : 8'(v.seed + 8'(i));
    send32(v.len, v.stall, v.bz, 1'b0);
    chk({nm, "_ld_latency"}, 128'(if32.blk_ld), 128'd1);
    chk({nm, "_busy_mid"}, 128'(if32.busy), 128'd1);
    guard = 0;
    while (tag_cnt == t0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk({nm, "_tag_count"}, 128'(tag_cnt - t0), 128'd1);
    chk({nm, "_busy_after"}, 128'(if32.busy), 128'd0);
    chk({nm, "_nblk"}, 128'(q_fb.size()), 128'(v.nblk));
    if (q_fb.size() == v.nblk) begin
      for (int k = 0; k < v.nblk; k++) begin
        chk({nm, "_fb"}, 128'(q_fb[k]), 128'(v.fb[k]));
        chk({nm, "_first"}, 128'(q_first[k]), 128'(k == 0));
      end
      chk({nm, "_last_m"}, q_m[v.nblk-1], v.last_m);
    end
    chk({nm, "_ready_in_flight"}, 128'(ready_viol), 128'd0);
    chk({nm, "_tag_align"}, 128'(tag_misalign), 128'd0);
    if (v.rfc) chk({nm, "_tag"}, last_tag, RFC_TAG);
  endtask

  initial begin
    int guard, ld0, tg0;
    tbl[0] = '{1,  8'hAB, 0, 0, 0, 1, 3'b000, 128'h01ab};
    tbl[1] = '{4,  8'h10, 1, 1, 0, 1, 3'b000, 128'h0113121110};
    tbl[2] = '{16, 8'h00, 0, 0, 0, 1, 3'b001, 128'h0f0e0d0c0b0a09080706050403020100};
    tbl[3] = '{17, 8'h00, 1, 0, 0, 2, 3'b001, 128'h0110};
    tbl[4] = '{32, 8'h20, 0, 1, 0, 2, 3'b011, 128'h3f3e3d3c3b3a39383736353433323130};
    tbl[5] = '{15, 8'h40, 1, 0, 0, 1, 3'b000, 128'h014e4d4c4b4a49484746454443424140};
    tbl[6] = '{7,  8'hF0, 0, 0, 0, 1, 3'b000, 128'h01f6f5f4f3f2f1f0};
    tbl[7] = '{34, 8'h00, 1, 0, 1, 3, 3'b011, 128'h017075};

    reset = 1'b0;
    if32.in_data = '0; if32.in_valid = 1'b0; if32.in_last = 1'b0; if32.in_bytes = '0;
    if8.in_data = '0;  if8.in_valid = 1'b0;  if8.in_last = 1'b0;  if8.in_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(if32.in_ready), 128'd0);
    chk("rst_ld", 128'(if32.blk_ld), 128'd0);
    chk("rst_tag", 128'(if32.tag_valid), 128'd0);
    chk("rst_busy", 128'(if32.busy), 128'd0);
    chk("rst_fb", 128'(if32.blk_fb), 128'd0);
    chk("rst_first", 128'(if32.blk_first), 128'd0);
    chk("rst_m", if32.blk_m, 128'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(if32.in_ready), 128'd1);

    // Back-to-back messages, including the RFC 8439 vector.
    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while the core holds a block, then a stray blk_rdy in FILL.
    core_lat = 20;
    for (int i = 0; i < 16; i++) msg[i] = 8'(8'h55 + 8'(i));
    send32(16, 1'b0, 1'b0, 1'b1);
    chk("wr_ld", 128'(if32.blk_ld), 128'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    core_cnt = 0;
    @(negedge clk);
    chk("wr_m", if32.blk_m, 128'd0);
    chk("wr_fb", 128'(if32.blk_fb), 128'd0);
    chk("wr_first", 128'(if32.blk_first), 128'd0);
    chk("wr_ld0", 128'(if32.blk_ld), 128'd0);
    chk("wr_tag", 128'(if32.tag_valid), 128'd0);
    chk("wr_busy", 128'(if32.busy), 128'd0);
    chk("wr_in_ready", 128'(if32.in_ready), 128'd0);
    reset = 1'b1;
    core_lat = 3;
    ld0 = ld_cnt; tg0 = tag_cnt;
    force_rdy = 1'b1;
    @(negedge clk);
    force_rdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_no_ld", 128'(ld_cnt - ld0), 128'd0);
    chk("stray_no_tag", 128'(tag_cnt - tg0), 128'd0);
    chk("stray_busy", 128'(if32.busy), 128'd0);
    chk("stray_in_ready", 128'(if32.in_ready), 128'd1);
    run_vec(tbl[0], "after_rst");

    // 8-bit build: 17 bytes 0x00..0x10.
    for (int i = 0; i < 17; i++) begin
      if8.in_data  = 8'(i);
      if8.in_last  = (i == 16);
      if8.in_bytes = 1'b1;
      if8.in_valid = 1'b1;
      guard = 0;
      while (!if8.in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) chk("w8_ready_timeout", 128'(guard), 128'd0);
      @(negedge clk);
    end
    if8.in_valid = 1'b0;
    if8.in_last  = 1'b0;
    guard = 0;
    while (tag8 == 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("w8_tag", 128'(tag8), 128'd1);
    chk("w8_nblk", 128'(q8_fb.size()), 128'd2);
    if (q8_fb.size() == 2) begin
      chk("w8_fb0", 128'(q8_fb[0]), 128'd1);
      chk("w8_fb1", 128'(q8_fb[1]), 128'd0);
      chk("w8_m0", q8_m[0], 128'h0f0e0d0c0b0a09080706050403020100);
      chk("w8_m1", q8_m[1], 128'h0110);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
